// File: rtl/definitions.vh
// rtl/definitions.vh - shared datapath width definitions
`ifndef DEFINITIONS_VH
`define DEFINITIONS_VH
`define WORD 32
`endif

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - two-requester regfile write-port arbiter
// Round-robin priority with a bounded lock, one-cycle registered write, X31 writes dropped.
`ifndef WORD
`include "definitions.vh"
`endif

module regfile_write_arbiter #(
  parameter int MAX_LOCK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [4:0]        req0_reg,
  input  logic [`WORD-1:0]  req0_data,
  input  logic              req0_lock,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [4:0]        req1_reg,
  input  logic [`WORD-1:0]  req1_data,
  input  logic              req1_lock,
  output logic              req1_ready,
  output logic [4:0]        write_register,
  output logic [`WORD-1:0]  write_data,
  output logic              RegWrite,
  output logic              grant_id,
  output logic              dropped_xzr
);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  localparam logic [3:0] MaxLock = 4'(MAX_LOCK);

  state_t           state_q, state_d;
  logic             rr_q, rr_d;
  logic [2:0]       lock_cnt_q, lock_cnt_d;
  logic             regwrite_q, dropped_q, grant_q;
  logic [4:0]       wreg_q;
  logic [`WORD-1:0] wdata_q;

  logic             pri, sel, xfer, sel_lock, owner, owner_valid;
  logic [4:0]       sel_reg;
  logic [`WORD-1:0] sel_data;
  logic [3:0]       cnt_inc;

  always_comb begin
    pri = rr_q;
    if (state_q == LOCK0) pri = 1'b0;
    else if (state_q == LOCK1) pri = 1'b1;
    sel      = (req0_valid && req1_valid) ? pri : req1_valid;
    xfer     = !reset && (req0_valid || req1_valid);
    sel_lock = sel ? req1_lock : req0_lock;
    sel_reg  = sel ? req1_reg : req0_reg;
    sel_data = sel ? req1_data : req0_data;
  end

  assign req0_ready = xfer && !sel;
  assign req1_ready = xfer && sel;

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    lock_cnt_d  = lock_cnt_q;
    owner       = (state_q == LOCK1);
    owner_valid = owner ? req1_valid : req0_valid;
    cnt_inc     = {1'b0, lock_cnt_q} + 4'd1;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (sel_lock) begin
            state_d    = sel ? LOCK1 : LOCK0;
            lock_cnt_d = 3'd1;
          end else begin
            rr_d = !sel;
          end
        end
      end
      LOCK0, LOCK1: begin
        // lock_cnt counts grants already held; the grant that reaches MAX_LOCK releases
        if (!owner_valid || !sel_lock || cnt_inc >= MaxLock) begin
          state_d    = IDLE;
          rr_d       = !owner;
          lock_cnt_d = 3'd0;
        end else begin
          lock_cnt_d = cnt_inc[2:0];
        end
      end
      default: begin
        state_d    = IDLE;
        lock_cnt_d = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_q       <= 1'b0;
      lock_cnt_q <= 3'd0;
      regwrite_q <= 1'b0;
      dropped_q  <= 1'b0;
      grant_q    <= 1'b0;
      wreg_q     <= 5'd0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      lock_cnt_q <= lock_cnt_d;
      regwrite_q <= 1'b0;
      dropped_q  <= 1'b0;
      if (xfer) begin
        grant_q <= sel;
        if (sel_reg == 5'd31) begin
          dropped_q <= 1'b1;
        end else begin
          regwrite_q <= 1'b1;
          wreg_q     <= sel_reg;
          wdata_q    <= sel_data;
        end
      end
    end
  end

  assign write_register = wreg_q;
  assign write_data     = wdata_q;
  assign RegWrite       = regwrite_q;
  assign grant_id       = grant_q;
  assign dropped_xzr    = dropped_q;

endmodule
